mips_mc_ctrl: RTL
=================

// Module: mips_mc_ctrl
// PURPOSE
//  Multicycle control sequencer for the MIPS core; replaces the free-running phase clocks with enable strobes in one clock domain.
//  Walks each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB.
//  Drives the PC, IR, register-file and memory enables and the datapath muxes, and waits on a memory ready handshake.
//  Halts on illegal opcode or memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a FETCH/MEM access waits for mem_ready before bus-error halt (>=1)
//  PERF_W       32  width of performance counters
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  run          in   1       level; 1 = execute, 0 = stop at next instruction boundary
//  opcode       in   6       IR[31:26], valid from DECODE onward
//  alu_zero     in   1       ALU zero flag, sampled in EXEC
//  mem_ready    in   1       memory access complete (same-cycle ack allowed)
//  state        out  3       IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
//  pc_en        out  1       load PC this cycle
//  pc_sel       out  2       0=PC+4  1=branch target  2=jump target
//  ir_en        out  1       load instruction register
//  mem_rd       out  1       memory read request (instr in FETCH, data in MEM)
//  mem_wr       out  1       memory write request
//  iord         out  1       0=address from PC, 1=address from ALU
//  alu_src_imm  out  1       ALU src2: 1=sign-extended imm, 0=reg_val_2
//  reg_dst_rd   out  1       write select: 1=rd (IR[15:11]), 0=rt
//  mem_to_reg   out  1       write data: 1=memory, 0=ALU result
//  reg_we       out  1       register-file write enable
//  instr_done   out  1       1-cycle pulse on the final cycle of each retired instruction
//  halted       out  1       1 in HALT
//  err_code     out  2       0=none 1=illegal opcode 2=bus timeout; valid while halted
//  cycle_cnt    out  PERF_W  cycles spent outside IDLE/HALT (see CONFIGURATION)
//  retire_cnt   out  PERF_W  retired instructions (see CONFIGURATION)
// BEHAVIOUR
//  - State is registered; all strobes decode combinationally from state, opcode, alu_zero and mem_ready.
//  - Reset: state=IDLE, timeout counter=0, err_code=0, perf counters=0. All strobes are 0 in IDLE and HALT.
//  - IDLE: run=1 -> FETCH; otherwise stay.
//  - FETCH: mem_rd=1, iord=0. On mem_ready, assert ir_en=1, pc_en=1, pc_sel=0, then -> DECODE.
//  - DECODE, by opcode:
//    - 0x02 j: pc_en=1, pc_sel=2, instr_done=1 -> FETCH.
//    - 0x00 R, 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq: -> EXEC.
//    - Any other opcode: -> HALT, err_code=1.
//  - EXEC: alu_src_imm=1 for addi/lw/sw, 0 otherwise.
//    - R, addi: -> WB.
//    - lw, sw: -> MEM.
//    - beq: if alu_zero, pc_en=1 and pc_sel=1. instr_done=1 -> FETCH.
//  - MEM: iord=1; mem_rd=1 for lw, mem_wr=1 for sw. Request is held until mem_ready.
//    - lw -> WB.
//    - sw: instr_done=1 -> FETCH.
//  - WB: reg_we=1, instr_done=1, then -> FETCH.
//    - reg_dst_rd=1 for R-type only.
//    - mem_to_reg=1 for lw only.
//  - Retire latency with mem_ready tied high: j=2, beq=3, R/addi/sw=4, lw=5 cycles.
//  - Timeout: counter clears on entry to FETCH/MEM and increments each cycle with mem_ready=0.
//    - If MEM_TIMEOUT cycles pass without mem_ready, go to HALT with err_code=2 and drop the strobes.
//    - A mem_ready in the same cycle the count hits the limit wins: no error.
//  - run=0 mid-instruction: the instruction completes. Any transition to FETCH goes to IDLE instead while run=0.
//  - HALT is sticky; only rst leaves it. rst has priority over every transition, mid-access included.
//  - pc_en and reg_we are never asserted in the same cycle as a transition into HALT.
// CONFIGURATION
//  MIPS_CTRL_PERF_EN defined:
//    - cycle_cnt increments each cycle in FETCH..WB.
//    - retire_cnt increments on instr_done.
//    - Both wrap modulo 2^PERF_W and are cleared by rst.
//  Undefined: cycle_cnt and retire_cnt are tied to 0 and no counter flops are built.
// TESTING
//  1. rst, run=1, mem_ready=1, opcode=0x00 -> states 1,2,3,5,1; reg_we=1 and reg_dst_rd=1 in WB; instr_done every 4 cycles.
//  2. opcode=0x23, mem_ready low 3 cycles in MEM -> mem_rd,iord held 4 cycles; WB has mem_to_reg=1, reg_we=1; lw retires in 8.
//  3. opcode=0x04 with alu_zero=1 -> pc_sel=1, pc_en=1 in EXEC. With alu_zero=0 -> pc_en=0 in EXEC. Both return to FETCH.
//  4. opcode=0x3F in DECODE -> HALT, halted=1, err_code=1, no strobes; holds with run=1 until rst -> IDLE.
//  5. mem_ready=0 in FETCH for 16 cycles -> HALT with err_code=2. Repeat with mem_ready=1 on 16th cycle -> DECODE, no error.
//  6. MIPS_CTRL_PERF_EN defined: 10 R-type instrs with mem_ready=1, run dropped after 10th -> retire_cnt=10, cycle_cnt=40, state=IDLE.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_ctrl
// Description : Multicycle control sequencer for the MIPS core. Steps each
//               instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB in a single
//               clock domain and emits per-cycle enable strobes and datapath
//               mux selects. Waits on a memory ready handshake and halts on
//               an illegal opcode or a memory access timeout.
// Ports       : clk, rst (sync, active-high)
//               run, opcode[5:0], alu_zero, mem_ready     - inputs
//               state[2:0], halted, err_code[1:0]         - status
//               pc_en, pc_sel[1:0], ir_en, mem_rd, mem_wr,
//               iord, alu_src_imm, reg_dst_rd, mem_to_reg,
//               reg_we, instr_done                        - strobes/selects
//               cycle_cnt, retire_cnt [PERF_W-1:0]        - perf counters
// Options     : MIPS_CTRL_PERF_EN - build the cycle/retire counters;
//               when undefined both outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [5:0]        opcode,
  input  logic              alu_zero,
  input  logic              mem_ready,
  output logic [2:0]        state,
  output logic              pc_en,
  output logic [1:0]        pc_sel,
  output logic              ir_en,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              iord,
  output logic              alu_src_imm,
  output logic              reg_dst_rd,
  output logic              mem_to_reg,
  output logic              reg_we,
  output logic              instr_done,
  output logic              halted,
  output logic [1:0]        err_code,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [5:0] c_op_r    = 6'h00;
  localparam logic [5:0] c_op_j    = 6'h02;
  localparam logic [5:0] c_op_beq  = 6'h04;
  localparam logic [5:0] c_op_addi = 6'h08;
  localparam logic [5:0] c_op_lw   = 6'h23;
  localparam logic [5:0] c_op_sw   = 6'h2B;

  localparam logic [1:0] c_err_none    = 2'd0;
  localparam logic [1:0] c_err_illegal = 2'd1;
  localparam logic [1:0] c_err_timeout = 2'd2;

  localparam int           TO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] c_to_last = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]      err_q, err_d;

  logic is_r, is_j, is_beq, is_addi, is_lw, is_sw;
  logic to_hit;
  state_e next_fetch;

  assign is_r    = (opcode == c_op_r);
  assign is_j    = (opcode == c_op_j);
  assign is_beq  = (opcode == c_op_beq);
  assign is_addi = (opcode == c_op_addi);
  assign is_lw   = (opcode == c_op_lw);
  assign is_sw   = (opcode == c_op_sw);

  // Counter already holds MEM_TIMEOUT-1 missed cycles, so this cycle is the
  // last one allowed; a ready seen now still completes the access.
  assign to_hit = (to_cnt_q == c_to_last);

  // Instruction boundary: a stop request diverts the next fetch to IDLE.
  assign next_fetch = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    to_cnt_d    = '0;
    pc_en       = 1'b0;
    pc_sel      = 2'd0;
    ir_en       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    iord        = 1'b0;
    alu_src_imm = 1'b0;
    reg_dst_rd  = 1'b0;
    mem_to_reg  = 1'b0;
    reg_we      = 1'b0;
    instr_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_HALT;
          err_d   = c_err_timeout;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_DECODE: begin
        if (is_j) begin
          pc_en      = 1'b1;
          pc_sel     = 2'd2;
          instr_done = 1'b1;
          state_d    = next_fetch;
        end else if (is_r || is_addi || is_lw || is_sw || is_beq) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_d   = c_err_illegal;
        end
      end

      S_EXEC: begin
        alu_src_imm = is_addi || is_lw || is_sw;
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_beq) begin
          pc_en      = alu_zero;
          pc_sel     = alu_zero ? 2'd1 : 2'd0;
          instr_done = 1'b1;
          state_d    = next_fetch;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        iord   = 1'b1;
        mem_rd = is_lw;
        mem_wr = ~is_lw;
        if (mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = next_fetch;
          end
        end else if (to_hit) begin
          state_d = S_HALT;
          err_d   = c_err_timeout;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        reg_dst_rd = is_r;
        mem_to_reg = is_lw;
        state_d    = next_fetch;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
      err_q    <= c_err_none;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign state    = state_q;
  assign halted   = (state_q == S_HALT);
  assign err_code = err_q;

`ifdef MIPS_CTRL_PERF_EN
  logic [PERF_W-1:0] cycle_q, cycle_d;
  logic [PERF_W-1:0] retire_q, retire_d;

  always_comb begin
    cycle_d  = cycle_q;
    retire_d = retire_q;
    if (state_q != S_IDLE && state_q != S_HALT) cycle_d = cycle_q + PERF_W'(1);
    if (instr_done) retire_d = retire_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule
`default_nettype wire
